imem_boot_loader: RTL and testbench

Upstream stage of the single-cycle processor. It receives a byte stream through a valid/ready handshake and assembles it into 32-bit instructions. It writes those instructions into instruction memory, then releases the processor's active-low reset and supplies the start PC. The processor runs only after a complete, valid program image has been written.

---
 rtl/imem_boot_pkg.sv | 21 ++
 rtl/imem_boot_loader_word_assembler.sv | 47 ++++
 rtl/imem_boot_loader.sv | 140 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_boot_pkg;

  // Width of the little-endian word-count header.
  localparam int LEN_W = 16;

  // Instruction bytes packed into one memory word.
  localparam int BYTES_PER_WORD = 4;

  // Loader control states.
  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    RUN,
    ERR
  } state_t;

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs four accepted stream bytes into one little-endian 32-bit word.
// The first byte of a word lands in bits [7:0].
module word_assembler
  import imem_boot_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_byte_o
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  // Next lane contents and lane index; clear wins over accept.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (accept_i) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d = idx_q + 2'd1;
    end
  end

  // Lane registers; reset drops any partially assembled word.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign last_byte_o = accept_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it into
// instruction memory one word at a time, then releases the processor.
// All outputs are decoded from registered state, so in_ready never
// depends combinationally on in_valid.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          MAX_WORDS = 256,
  parameter logic [63:0] START_PC  = 64'h0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              go,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset_n,
  output logic [63:0]       start_pc,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(MAX_WORDS);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [ADDR_W:0]     words_q, words_d;

  logic                accept;
  logic                asm_clear;
  logic                asm_accept;
  logic                last_byte;
  logic [31:0]         asm_word;
  logic [LEN_W-1:0]    len_full;
  logic [LEN_W:0]      next_count;

  assign accept     = in_valid && in_ready;
  assign asm_accept = accept && (state_q == DATA);
  assign len_full   = {in_byte, len_q[7:0]};
  assign next_count = (LEN_W + 1)'(word_idx_q) + (LEN_W + 1)'(1);

  word_assembler u_asm (
    .CLK         (CLK),
    .reset       (reset),
    .clear_i     (asm_clear),
    .accept_i    (asm_accept),
    .byte_i      (in_byte),
    .word_o      (asm_word),
    .last_byte_o (last_byte)
  );

  // Next-state and counter updates for the load sequence.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    words_d    = words_q;
    asm_clear  = 1'b0;
    case (state_q)
      IDLE, RUN, ERR: begin
        if (go) begin
          state_d    = LEN0;
          len_d      = '0;
          word_idx_d = '0;
          words_d    = '0;
          asm_clear  = 1'b1;
        end
      end
      LEN0: begin
        if (accept) begin
          len_d[7:0] = in_byte;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == '0) begin
            state_d = RUN;
          end else if ({1'b0, len_full} > MAX_LEN) begin
            state_d = ERR;
          end else begin
            state_d    = DATA;
            word_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (last_byte) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + ADDR_W'(1);
        words_d    = words_q + (ADDR_W + 1)'(1);
        if (next_count == {1'b0, len_q}) begin
          state_d = RUN;
        end else begin
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, length and counter registers.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      words_q    <= words_d;
    end
  end

  assign in_ready     = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA);
  assign busy         = (state_q == LEN0) || (state_q == LEN1) ||
                        (state_q == DATA) || (state_q == WRITE);
  assign imem_we      = (state_q == WRITE);
  assign imem_waddr   = word_idx_q;
  assign imem_wdata   = asm_word;
  assign cpu_reset_n  = (state_q == RUN);
  assign done         = (state_q == RUN);
  assign err_overflow = (state_q == ERR);
  assign start_pc     = START_PC;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a byte-count based reference model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_imem_boot_loader;

  localparam int          ADDR_W    = 8;
  localparam int          MAX_WORDS = 256;
  localparam logic [63:0] START_PC  = 64'h0000_0000_8000_0040;

  logic              CLK;
  logic              reset;
  logic              go;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset_n;
  logic [63:0]       start_pc;
  logic              busy;
  logic              done;
  logic              err_overflow;
  logic [ADDR_W:0]   words_loaded;

  imem_boot_loader #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (MAX_WORDS),
    .START_PC  (START_PC)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .go           (go),
    .in_valid     (in_valid),
    .in_byte      (in_byte),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_reset_n  (cpu_reset_n),
    .start_pc     (start_pc),
    .busy         (busy),
    .done         (done),
    .err_overflow (err_overflow),
    .words_loaded (words_loaded)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: cycle budget expired at %0t", name, $time);
  endtask

  // Reference model: tracks the load by counting accepted bytes.
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_ERR} mmode_t;
  mmode_t      m_mode = M_IDLE;
  int          m_nacc = 0;
  int          m_len  = 0;
  int          m_wl   = 0;
  bit          m_wr   = 1'b0;
  int          m_addr = 0;
  logic [31:0] m_cur  = '0;
  logic [31:0] m_word = '0;

  // Observed writes, recorded by the compare process only.
  logic [31:0] seen [0:MAX_WORDS-1];
  int          wr_total = 0;

  task automatic model_step(input logic r, input logic g, input logic v, input logic [7:0] b);
    bit rdy;
    int k;
    rdy = (m_mode == M_LOAD) && !m_wr;
    if (!r) begin
      m_mode = M_IDLE; m_wr = 1'b0; m_nacc = 0; m_wl = 0; m_len = 0;
    end else if (m_mode != M_LOAD) begin
      if (g) begin
        m_mode = M_LOAD; m_nacc = 0; m_wl = 0; m_wr = 1'b0;
      end
    end else if (m_wr) begin
      m_wr = 1'b0;
      m_wl++;
      if (m_wl == m_len) m_mode = M_RUN;
    end else if (v && rdy) begin
      if (m_nacc == 0) begin
        m_len = int'(b);
      end else if (m_nacc == 1) begin
        m_len = m_len + 256 * int'(b);
        if (m_len == 0) m_mode = M_RUN;
        else if (m_len > MAX_WORDS) m_mode = M_ERR;
      end else begin
        k = (m_nacc - 2) % 4;
        m_cur[8*k +: 8] = b;
        if (k == 3) begin
          m_wr   = 1'b1;
          m_addr = (m_nacc - 2) / 4;
          m_word = m_cur;
        end
      end
      m_nacc++;
    end
  endtask

  // Compare process: update model at posedge, check outputs at negedge.
  initial begin
    forever begin
      @(posedge CLK);
      model_step(reset, go, in_valid, in_byte);
      @(negedge CLK);
      check("in_ready",     64'(in_ready),     64'((m_mode == M_LOAD) && !m_wr));
      check("busy",         64'(busy),         64'(m_mode == M_LOAD));
      check("done",         64'(done),         64'(m_mode == M_RUN));
      check("cpu_reset_n",  64'(cpu_reset_n),  64'(m_mode == M_RUN));
      check("err_overflow", 64'(err_overflow), 64'(m_mode == M_ERR));
      check("imem_we",      64'(imem_we),      64'(m_wr));
      check("words_loaded", 64'(words_loaded), 64'(m_wl));
      check("start_pc",     start_pc,          START_PC);
      if (m_wr) begin
        check("imem_waddr", 64'(imem_waddr), 64'(m_addr));
        check("imem_wdata", 64'(imem_wdata), 64'(m_word));
      end
      if (imem_we) begin
        wr_total++;
        seen[imem_waddr] = imem_wdata;
      end
    end
  end

  task automatic pulse_go();
    @(negedge CLK);
    go = 1'b1;
    in_valid = 1'b0;
    @(negedge CLK);
    go = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int  n;
    bit  sent;
    n = 0;
    sent = 1'b0;
    while (!sent && n < 50) begin
      @(negedge CLK);
      in_byte  = b;
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid && in_ready) sent = 1'b1;
      n++;
    end
    if (!sent) bound_fail("send_byte");
  endtask

  task automatic send_image(input logic [7:0] bytes [$], input bit rnd);
    foreach (bytes[i]) send_byte(bytes[i], rnd);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic wait_flag(input string name, input bit want_err, input int budget);
    int n;
    n = 0;
    while (!(want_err ? err_overflow : done) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (!(want_err ? err_overflow : done)) bound_fail(name);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_reset_n"}, 64'(cpu_reset_n),  64'd0);
    check({tag, "_busy"},        64'(busy),         64'd0);
    check({tag, "_done"},        64'(done),         64'd0);
    check({tag, "_err"},         64'(err_overflow), 64'd0);
    check({tag, "_in_ready"},    64'(in_ready),     64'd0);
    check({tag, "_imem_we"},     64'(imem_we),      64'd0);
    check({tag, "_waddr"},       64'(imem_waddr),   64'd0);
    check({tag, "_wdata"},       64'(imem_wdata),   64'd0);
    check({tag, "_words"},       64'(words_loaded), 64'd0);
    check({tag, "_start_pc"},    start_pc,          64'h0000_0000_8000_0040);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed scenarios.
  initial begin
    logic [7:0]  img [$];
    logic [7:0]  big [$];
    logic [31:0] w;
    int          w0;

    reset = 1'b0; go = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    repeat (2) @(negedge CLK);
    check_all_zero("t1_reset");

    // Stream activity without go must not be accepted.
    reset = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'hFF;
    repeat (3) @(negedge CLK);
    check("t1_no_go_in_ready", 64'(in_ready), 64'd0);
    check("t1_no_go_busy",     64'(busy),     64'd0);
    in_valid = 1'b0;

    // Two-word image, continuous valid.
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h8B, 8'h44, 8'h33, 8'h22, 8'h11};
    w0 = wr_total;
    pulse_go();
    check("t2_busy_after_go", 64'(busy), 64'd1);
    send_image(img, 1'b0);
    wait_flag("t2_run", 1'b0, 20);
    check("t2_cpu_reset_n", 64'(cpu_reset_n),  64'd1);
    check("t2_words",       64'(words_loaded), 64'd2);
    check("t2_nwrites",     64'(wr_total - w0), 64'd2);
    check("t2_word0",       64'(seen[0]), 64'h8B00_0013);
    check("t2_word1",       64'(seen[1]), 64'h1122_3344);

    // Same image with irregular valid.
    w0 = wr_total;
    pulse_go();
    check("t3_cpu_reset_n_low", 64'(cpu_reset_n), 64'd0);
    check("t3_words_cleared",   64'(words_loaded), 64'd0);
    send_image(img, 1'b1);
    wait_flag("t3_run", 1'b0, 40);
    check("t3_words",   64'(words_loaded), 64'd2);
    check("t3_nwrites", 64'(wr_total - w0), 64'd2);
    check("t3_word0",   64'(seen[0]), 64'h8B00_0013);
    check("t3_word1",   64'(seen[1]), 64'h1122_3344);

    // Oversized header: 257 words.
    w0 = wr_total;
    pulse_go();
    send_image('{8'h01, 8'h01}, 1'b0);
    wait_flag("t4_err", 1'b1, 10);
    repeat (3) @(negedge CLK);
    check("t4_err",         64'(err_overflow),  64'd1);
    check("t4_cpu_reset_n", 64'(cpu_reset_n),   64'd0);
    check("t4_nwrites",     64'(wr_total - w0), 64'd0);
    w0 = wr_total;
    pulse_go();
    check("t4_err_cleared", 64'(err_overflow), 64'd0);
    send_image('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 1'b0);
    wait_flag("t4_run", 1'b0, 20);
    check("t4_done",    64'(done),          64'd1);
    check("t4_word0",   64'(seen[0]),       64'h1234_5678);
    check("t4_nwrites2", 64'(wr_total - w0), 64'd1);

    // Empty image, then restart from RUN.
    w0 = wr_total;
    pulse_go();
    send_image('{8'h00, 8'h00}, 1'b0);
    wait_flag("t5_run", 1'b0, 10);
    check("t5_nwrites", 64'(wr_total - w0), 64'd0);
    check("t5_words",   64'(words_loaded),  64'd0);
    check("t5_cpu_up",  64'(cpu_reset_n),   64'd1);
    pulse_go();
    check("t5_cpu_down", 64'(cpu_reset_n), 64'd0);
    check("t5_busy",     64'(busy),        64'd1);

    // Reset in the middle of word 1, then a fresh one-word load.
    send_image('{8'h02, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2}, 1'b0);
    @(negedge CLK);
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    check_all_zero("t6_reset");
    reset = 1'b1;
    w0 = wr_total;
    pulse_go();
    send_image('{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04}, 1'b0);
    wait_flag("t6_run", 1'b0, 20);
    check("t6_word0",   64'(seen[0]),       64'h0403_0201);
    check("t6_nwrites", 64'(wr_total - w0), 64'd1);
    check("t6_words",   64'(words_loaded),  64'd1);

    // Largest accepted image: exactly MAX_WORDS words.
    big = '{8'h00, 8'h01};
    for (int i = 0; i < MAX_WORDS; i++) begin
      w = {8'(i), 8'(~i), 8'(i ^ 8'h5A), 8'hC3};
      for (int j = 0; j < 4; j++) big.push_back(w[8*j +: 8]);
    end
    w0 = wr_total;
    pulse_go();
    send_image(big, 1'b0);
    wait_flag("t7_run", 1'b0, 20);
    check("t7_nwrites", 64'(wr_total - w0), 64'd256);
    check("t7_words",   64'(words_loaded),  64'd256);
    check("t7_word0",   64'(seen[0]),       64'h00FF_5AC3);
    check("t7_word255", 64'(seen[255]),     64'hFF00_A5C3);
    check("t7_err",     64'(err_overflow),  64'd0);

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
